router_port_arbiter: RTL

- Clocked output-port scheduler for the 3-port tree router (child 1, child 2, parent); it shares one router output link between the three requesters.
- Packet-granular arbitration: a grant is held from the first flit of a packet through its last flit.
- Round-robin by default. Optional parent priority, bounded by an anti-starvation age counter per child.
- Single registered output stage with valid/ready flow control.

---
 rtl/router_port_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/router_port_arbiter.sv
// ----------------------------------------------------------------------------
// router_port_arbiter
//
// Output-port scheduler for the 3-port tree router. Three requesters
// (0 = child 1, 1 = child 2, 2 = parent) share one output link. Arbitration
// is packet-granular: once a packet's first flit wins, the grant is held
// until its last flit has been accepted. Packet starts are decided
// round-robin, optionally with parent priority, and any input that has
// waited AGE_MAX cycles is forced to win.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   req_data   in   3*WIDTH flit per input, slice i = [i*WIDTH +: WIDTH]
//   req_valid  in   3 flit present on input i
//   req_last   in   3 flit on input i is the last of its packet
//   req_ready  out  3 input i's flit is accepted this cycle (combinational)
//   out_data   out  WIDTH registered output flit
//   out_valid  out  output flit present
//   out_last   out  output flit is the last of its packet
//   out_ready  in   downstream accepts the output flit
//   grant_id   out  2 input owning the current or most recent packet
//   locked     out  a packet is in progress (grant held)
//   pkt_cnt    out  16 count of last flits transferred at the output, wraps
// ----------------------------------------------------------------------------
module router_port_arbiter #(
    parameter int WIDTH       = 32,
    parameter int PARENT_PRIO = 0,
    parameter int AGE_MAX     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3*WIDTH-1:0] req_data,
    input  logic [2:0]         req_valid,
    input  logic [2:0]         req_last,
    output logic [2:0]         req_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic [1:0]         grant_id,
    output logic               locked,
    output logic [15:0]        pkt_cnt
);

    localparam int            AW      = $clog2(AGE_MAX + 1);
    localparam logic [AW-1:0] AGE_LIM = AW'(AGE_MAX);
    localparam logic [AW-1:0] AGE_ONE = AW'(1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [1:0]         r_grantId;
    logic [1:0]         r_rrPtr;
    logic [AW-1:0]      r_age [3];
    logic [WIDTH-1:0]   r_outData;
    logic               r_outValid;
    logic               r_outLast;
    logic [15:0]        r_pktCnt;

    logic               w_slotFree;
    logic [2:0]         w_aged;
    logic [1:0]         w_rr1;
    logic [1:0]         w_rr2;
    logic [1:0]         w_win;
    logic [2:0]         w_ready;
    logic               w_accept;
    logic [1:0]         w_accIdx;
    logic               w_accLast;
    logic [WIDTH-1:0]   w_accData;

    function automatic logic [1:0] nextIdx(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic bitAt(input logic [2:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    return v[0];
            2'd1:    return v[1];
            2'd2:    return v[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] oneHot(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // The output register can take a new flit when empty or draining now.
    assign w_slotFree = !r_outValid || out_ready;

    assign w_aged[0] = req_valid[0] && (r_age[0] == AGE_LIM);
    assign w_aged[1] = req_valid[1] && (r_age[1] == AGE_LIM);
    assign w_aged[2] = req_valid[2] && (r_age[2] == AGE_LIM);

    assign w_rr1 = nextIdx(r_rrPtr);
    assign w_rr2 = nextIdx(w_rr1);

    // Packet-start winner: aged inputs first, then parent priority, then
    // round-robin starting at r_rrPtr.
    always_comb begin
        w_win = r_rrPtr;
        if (w_aged[0]) begin
            w_win = 2'd0;
        end else if (w_aged[1]) begin
            w_win = 2'd1;
        end else if (w_aged[2]) begin
            w_win = 2'd2;
        end else if ((PARENT_PRIO != 0) && req_valid[2]) begin
            w_win = 2'd2;
        end else if (bitAt(req_valid, r_rrPtr)) begin
            w_win = r_rrPtr;
        end else if (bitAt(req_valid, w_rr1)) begin
            w_win = w_rr1;
        end else if (bitAt(req_valid, w_rr2)) begin
            w_win = w_rr2;
        end
    end

    // Ready is forced low while reset is asserted so nothing is offered
    // an accept during reset.
    always_comb begin
        w_ready = 3'b000;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_slotFree && (|req_valid)) begin
                        w_ready = oneHot(w_win);
                    end
                end
                ST_LOCKED: begin
                    if (w_slotFree) begin
                        w_ready = oneHot(r_grantId);
                    end
                end
                default: w_ready = 3'b000;
            endcase
        end
    end

    assign req_ready = w_ready;
    assign w_accept  = |(req_valid & w_ready);
    assign w_accIdx  = (r_state == ST_LOCKED) ? r_grantId : w_win;
    assign w_accLast = bitAt(req_last, w_accIdx);

    always_comb begin
        w_accData = req_data[0 +: WIDTH];
        case (w_accIdx)
            2'd1:    w_accData = req_data[WIDTH +: WIDTH];
            2'd2:    w_accData = req_data[2*WIDTH +: WIDTH];
            default: w_accData = req_data[0 +: WIDTH];
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_accLast) begin
                    w_nextState = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_accLast) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Grant owner and round-robin pointer only move at packet start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grantId <= 2'd0;
            r_rrPtr   <= 2'd0;
        end else begin
            r_state <= w_nextState;
            if (w_accept && (r_state == ST_IDLE)) begin
                r_grantId <= w_win;
                r_rrPtr   <= nextIdx(w_win);
            end
        end
    end

    // A transfer and a new load in the same cycle reload without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_outData  <= w_accData;
                r_outLast  <= w_accLast;
                r_outValid <= 1'b1;
            end else if (out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pktCnt <= 16'd0;
        end else if (r_outValid && out_ready && r_outLast) begin
            r_pktCnt <= r_pktCnt + 16'd1;
        end
    end

    // Ages count every cycle an input waits, including lock and stall time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i] || w_ready[i]) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != AGE_LIM) begin
                    r_age[i] <= r_age[i] + AGE_ONE;
                end
            end
        end
    end

    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;
    assign grant_id  = r_grantId;
    assign locked    = (r_state == ST_LOCKED);
    assign pkt_cnt   = r_pktCnt;

endmodule
